afe_command_sequencer: RTL

Upstream command source for the AFE serial output stage. It holds a small writable table of 20-bit AFE commands and, on a `go` pulse, issues them in order to the serial stage through its `start_transaction`/`transaction_done` handshake. A programmable dead-time gap follows each completed command. The block lets the controller program the AFE with a single trigger instead of sequencing every word itself.

---
 rtl/afe_command_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/afe_command_sequencer.sv
// Command-table sequencer feeding the AFE serial output stage over a start/done handshake.
// Optional per-command watchdog enabled by defining AFE_SEQ_TIMEOUT_EN.
module afe_command_sequencer #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [19:0]       i_wr_data,
  input  logic [ADDR_W:0]   i_seq_length,
  input  logic              i_go,
  output logic              o_afe_start,
  output logic [19:0]       o_afe_command,
  input  logic              i_afe_done,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_cmd_index,
  output logic              o_seq_done,
  output logic              o_error
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [ADDR_W:0]   LP_DEPTH    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] LP_IDX_ONE  = ADDR_W'(1);
  localparam logic [GAP_W-1:0]  LP_GAP      = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0]  LP_GAP_ONE  = GAP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [19:0]       r_mem [DEPTH];
  logic [19:0]       r_rd_data;
  logic              r_load_ph;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_cmd_index;
  logic [GAP_W-1:0]  r_gap;
  logic              r_afe_start;
  logic [19:0]       r_afe_command;
  logic              r_busy;
  logic              r_seq_done;

  logic [ADDR_W:0]   w_len;
  logic              w_last;
  logic              w_cmd_end;

`ifdef AFE_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] LP_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] LP_TO_ONE  = TO_W'(1);
  logic [TO_W-1:0] r_to;
  logic            r_error;
`endif

  always_comb begin
    w_len     = (i_seq_length > LP_DEPTH) ? LP_DEPTH : i_seq_length;
    w_last    = ({1'b0, r_cmd_index} == (r_len - LP_LEN_ONE));
    // A command finishes either straight out of WAIT (no gap) or on the last gap clock.
    w_cmd_end = ((r_state == S_WAIT) && i_afe_done && (GAP_CYCLES == 0)) ||
                ((r_state == S_GAP) && (r_gap == LP_GAP_ONE));
  end

  // Table writes are only honoured while idle; the table is never cleared.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (r_state == S_IDLE)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_rd_data     <= 20'h00000;
      r_load_ph     <= 1'b0;
      r_len         <= '0;
      r_cmd_index   <= '0;
      r_gap         <= '0;
      r_afe_start   <= 1'b0;
      r_afe_command <= 20'h00000;
      r_busy        <= 1'b0;
      r_seq_done    <= 1'b0;
`ifdef AFE_SEQ_TIMEOUT_EN
      r_to          <= '0;
      r_error       <= 1'b0;
`endif
    end else begin
      r_seq_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_go) begin
            r_len       <= w_len;
            r_cmd_index <= '0;
`ifdef AFE_SEQ_TIMEOUT_EN
            r_error     <= 1'b0;
`endif
            if (w_len == '0) begin
              r_seq_done <= 1'b1;
            end else begin
              r_state   <= S_LOAD;
              r_busy    <= 1'b1;
              r_load_ph <= 1'b0;
            end
          end
        end
        // LOAD spends one clock on the registered table read, then issues the request.
        S_LOAD: begin
`ifdef AFE_SEQ_TIMEOUT_EN
          r_to <= '0;
`endif
          if (!r_load_ph) begin
            r_rd_data <= r_mem[r_cmd_index];
            r_load_ph <= 1'b1;
          end else begin
            r_afe_command <= r_rd_data;
            r_afe_start   <= 1'b1;
            r_state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (!i_afe_done) begin
            r_afe_start <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_afe_done && (GAP_CYCLES != 0)) begin
            r_gap   <= LP_GAP;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap != LP_GAP_ONE) begin
            r_gap <= r_gap - LP_GAP_ONE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_afe_start <= 1'b0;
        end
      endcase

      if (w_cmd_end) begin
        if (w_last) begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_seq_done <= 1'b1;
        end else begin
          r_cmd_index <= r_cmd_index + LP_IDX_ONE;
          r_load_ph   <= 1'b0;
          r_state     <= S_LOAD;
        end
      end

`ifdef AFE_SEQ_TIMEOUT_EN
      // Watchdog abort takes priority over any normal completion in the same clock.
      if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
        if (r_to == LP_TO_LAST) begin
          r_error     <= 1'b1;
          r_afe_start <= 1'b0;
          r_busy      <= 1'b0;
          r_seq_done  <= 1'b0;
          r_state     <= S_IDLE;
        end else begin
          r_to <= r_to + LP_TO_ONE;
        end
      end
`endif
    end
  end

  assign o_afe_start   = r_afe_start;
  assign o_afe_command = r_afe_command;
  assign o_busy        = r_busy;
  assign o_cmd_index   = r_cmd_index;
  assign o_seq_done    = r_seq_done;
`ifdef AFE_SEQ_TIMEOUT_EN
  assign o_error       = r_error;
`else
  assign o_error       = 1'b0;
`endif

endmodule
